// File: rtl/vvalu_cfg_pkg.sv
// Shared types and helpers for the vectorVectorALU configuration sequencer.
// Byte layout of the firmware table is field-major: index = field*MAX_CHAINS + chain.
package vvalu_cfg_pkg;

    localparam int NUM_FIELDS = 6;
    localparam logic [7:0] IDLE_CONFIG_ID_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        FLD_OP         = 3'd0,
        FLD_ADDR_RD    = 3'd1,
        FLD_COND       = 3'd2,
        FLD_CACHE      = 3'd3,
        FLD_CACHE_ADDR = 3'd4,
        FLD_MINICACHE  = 3'd5
    } field_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRE    = 2'd1,
        STREAM = 2'd2,
        POST   = 2'd3
    } state_e;

    function automatic int unsigned byte_index(input int unsigned field,
                                               input int unsigned chain,
                                               input int unsigned max_chains);
        return field * max_chains + chain;
    endfunction

endpackage

// File: rtl/vvalu_config_sequencer_if.sv
// Host-side bus of the config sequencer: shadow-table writes, load request,
// the configId/configData broadcast bus and the status pulses.
interface vvalu_config_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              host_wr_en;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [7:0]        host_wr_data;
    logic              start;
    logic [7:0]        configId;
    logic [7:0]        configData;
    logic              busy;
    logic              pending;
    logic              done;
    logic              aborted;
    logic              wr_ignored;

    modport master (
        output host_wr_en, host_wr_addr, host_wr_data, start,
        input  configId, configData, busy, pending, done, aborted, wr_ignored
    );

    modport slave (
        input  host_wr_en, host_wr_addr, host_wr_data, start,
        output configId, configData, busy, pending, done, aborted, wr_ignored
    );
endinterface

// File: rtl/vvalu_cfg_shadow.sv
// Shadow firmware table: flop array with one synchronous write port and a
// combinational read port; every byte clears on reset.
module vvalu_cfg_shadow #(
    parameter int TOTAL_BYTES = 24,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [TOTAL_BYTES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TOTAL_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (rd_addr < ADDR_W'(TOTAL_BYTES)) ? mem[rd_addr] : '0;

endmodule

// File: rtl/vvalu_config_sequencer.sv
// Streams the shadow firmware table onto the configId/configData bus of one
// vectorVectorALU, framed by idle IDs so the ALU byte counter starts and ends at 0.
module vvalu_config_sequencer
    import vvalu_cfg_pkg::*;
#(
    parameter int         MAX_CHAINS       = 4,
    parameter logic [7:0] TARGET_CONFIG_ID = 8'd0,
    parameter logic [7:0] IDLE_CONFIG_ID   = IDLE_CONFIG_ID_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tracing,
    vvalu_config_sequencer_if.slave  bus
);

    localparam int TOTAL_BYTES = MAX_CHAINS * NUM_FIELDS;
    localparam int ADDR_W      = $clog2(TOTAL_BYTES);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(TOTAL_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(TOTAL_BYTES);

    state_e            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              launch, launch_n;
    logic              pending_n;
    logic              abort_n;
    logic              wr_ok;
    logic [7:0]        shadow_rd;

    // Writes are only safe while the table is not being streamed.
    assign wr_ok = bus.host_wr_en && !bus.busy && (bus.host_wr_addr < ADDR_LIMIT);

    vvalu_cfg_shadow #(
        .TOTAL_BYTES (TOTAL_BYTES),
        .DATA_W      (8),
        .ADDR_W      (ADDR_W)
    ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (bus.host_wr_addr),
        .wr_data (bus.host_wr_data),
        .rd_addr (cnt_n),
        .rd_data (shadow_rd)
    );

    // state tracks the phase visible on the bus; launch is the one-cycle gap
    // between sampling start and showing PRE.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        launch_n  = launch;
        pending_n = bus.pending;
        abort_n   = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_n  = PRE;
                    launch_n = 1'b0;
                end else if (bus.pending) begin
                    if (!tracing) begin
                        state_n   = PRE;
                        pending_n = 1'b0;
                    end
                end else if (bus.start) begin
                    if (tracing) pending_n = 1'b1;
                    else         launch_n  = 1'b1;
                end
            end
            PRE: begin
                if (tracing) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                end else begin
                    state_n = STREAM;
                    cnt_n   = '0;
                end
            end
            STREAM: begin
                if (tracing) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                end else if (cnt == LAST_IDX) begin
                    state_n = POST;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            POST:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            launch         <= 1'b0;
            bus.configId   <= IDLE_CONFIG_ID;
            bus.configData <= 8'd0;
            bus.busy       <= 1'b0;
            bus.pending    <= 1'b0;
            bus.done       <= 1'b0;
            bus.aborted    <= 1'b0;
            bus.wr_ignored <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            launch         <= launch_n;
            bus.configId   <= (state_n == STREAM) ? TARGET_CONFIG_ID : IDLE_CONFIG_ID;
            bus.configData <= (state_n == STREAM) ? shadow_rd : 8'd0;
            bus.busy       <= (state_n == PRE) || (state_n == STREAM);
            bus.pending    <= pending_n;
            bus.done       <= (state_n == POST);
            bus.aborted    <= abort_n;
            bus.wr_ignored <= bus.host_wr_en && !wr_ok;
        end
    end

endmodule

// File: tb/tb_vvalu_config_sequencer.sv
// Directed bench for vvalu_config_sequencer: loads, deferred start, abort,
// write protection, reset mid-stream and same-cycle write/start.
module tb_vvalu_config_sequencer;
    import vvalu_cfg_pkg::*;

    localparam logic [7:0] ID_IDLE = 8'hFF;
    localparam logic [7:0] ID_TGT  = 8'h00;

    logic clk = 1'b0;
    logic reset;
    logic tracing;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] exp_mem [24];
    logic [7:0] fw [24];
    int   alu_cnt = 0;

    vvalu_config_sequencer_if #(.ADDR_W(5)) bus ();

    vvalu_config_sequencer #(
        .MAX_CHAINS       (4),
        .TARGET_CONFIG_ID (8'h00),
        .IDLE_CONFIG_ID   (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tracing (tracing),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Downstream ALU model: byte counter runs only while its ID is selected.
    always @(posedge clk) begin
        if (reset || bus.configId != ID_TGT) begin
            alu_cnt <= 0;
        end else begin
            if (alu_cnt < 24) fw[alu_cnt] <= bus.configData;
            alu_cnt <= alu_cnt + 1;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] bv(input logic [7:0] id, input logic [7:0] d,
                                       input logic b, input logic p, input logic dn,
                                       input logic ab, input logic wi);
        return {11'd0, id, d, b, p, dn, ab, wi};
    endfunction

    function automatic logic [31:0] ov();
        return {11'd0, bus.configId, bus.configData, bus.busy, bus.pending,
                bus.done, bus.aborted, bus.wr_ignored};
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic host_write(input logic [4:0] addr, input logic [7:0] data);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_addr = addr;
        bus.host_wr_data = data;
        step();
        bus.host_wr_en   = 1'b0;
    endtask

    task automatic expect_pre(input string tag);
        step();
        chk({tag, "_pre"}, ov(), bv(ID_IDLE, 8'd0, 1, 0, 0, 0, 0));
    endtask

    task automatic stream_bytes(input string tag, input int first, input int last);
        for (int j = first; j <= last; j++) begin
            step();
            chk($sformatf("%s_b%0d", tag, j), ov(), bv(ID_TGT, exp_mem[j], 1, 0, 0, 0, 0));
        end
    endtask

    task automatic expect_post(input string tag);
        step();
        chk({tag, "_done"}, ov(), bv(ID_IDLE, 8'd0, 0, 0, 1, 0, 0));
        step();
        chk({tag, "_idle"}, ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));
    endtask

    task automatic full_load(input string tag);
        pulse_start();
        chk({tag, "_launch"}, ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));
        expect_pre(tag);
        stream_bytes(tag, 0, 23);
        expect_post(tag);
    endtask

    initial begin
        reset            = 1'b1;
        tracing          = 1'b0;
        bus.host_wr_en   = 1'b0;
        bus.host_wr_addr = '0;
        bus.host_wr_data = '0;
        bus.start        = 1'b0;
        step();
        step();
        chk("reset", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        step();

        // Plain load with shadow[j] = j+1.
        for (int f = 0; f < NUM_FIELDS; f++) begin
            for (int c = 0; c < 4; c++) begin
                host_write(5'(byte_index(f, c, 4)), 8'(byte_index(f, c, 4) + 1));
                exp_mem[byte_index(f, c, 4)] = 8'(byte_index(f, c, 4) + 1);
            end
        end
        chk("wr_ok_no_ignore", {31'd0, bus.wr_ignored}, 32'd0);
        full_load("load");
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("fw_op%0d", c), {24'd0, fw[byte_index(FLD_OP, c, 4)]}, 32'(c + 1));
        end

        // Deferred start: tracing high for 10 sampled edges, extra start while pending.
        tracing = 1'b1;
        pulse_start();
        chk("defer_pend0", ov(), bv(ID_IDLE, 8'd0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 9; i++) begin
            if (i == 3) bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            chk($sformatf("defer_pend%0d", i + 1), ov(), bv(ID_IDLE, 8'd0, 0, 1, 0, 0, 0));
        end
        tracing = 1'b0;
        expect_pre("defer");
        stream_bytes("defer", 0, 23);
        expect_post("defer");

        // Write during stream is dropped, then abort at byte 7.
        pulse_start();
        chk("abort_launch", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));
        expect_pre("abort");
        stream_bytes("abort", 0, 0);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_addr = 5'd3;
        bus.host_wr_data = 8'h55;
        step();
        bus.host_wr_en   = 1'b0;
        chk("busy_wr_ignored", ov(), bv(ID_TGT, exp_mem[1], 1, 0, 0, 0, 1));
        stream_bytes("abort", 2, 7);
        tracing = 1'b1;
        step();
        chk("abort_pulse", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 1, 0));
        tracing = 1'b0;
        step();
        chk("abort_idle", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));
        full_load("reload");

        // Out-of-range write while idle.
        host_write(5'd24, 8'h77);
        chk("oor_wr_ignored", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 1));
        step();
        chk("oor_wr_clear", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));

        // Same-cycle write and start, then reset at byte 12.
        bus.host_wr_en   = 1'b1;
        bus.host_wr_addr = 5'd0;
        bus.host_wr_data = 8'hAA;
        bus.start        = 1'b1;
        step();
        bus.host_wr_en   = 1'b0;
        bus.start        = 1'b0;
        exp_mem[0]       = 8'hAA;
        chk("same_launch", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));
        expect_pre("same");
        stream_bytes("same", 0, 12);
        reset = 1'b1;
        step();
        chk("midreset", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("midreset_quiet%0d", i), ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));
        end
        for (int j = 0; j < 24; j++) exp_mem[j] = 8'd0;
        full_load("readback");

        // Tracing rises while the last byte is on the bus.
        for (int j = 0; j < 24; j++) begin
            host_write(5'(j), 8'(8'hC0 + j));
            exp_mem[j] = 8'(8'hC0 + j);
        end
        pulse_start();
        chk("late_launch", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));
        expect_pre("late");
        stream_bytes("late", 0, 23);
        tracing = 1'b1;
        step();
        chk("late_abort", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 1, 0));
        tracing = 1'b0;
        step();
        chk("late_idle", ov(), bv(ID_IDLE, 8'd0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vvalu_config_sequencer.md
Name: vvalu_config_sequencer

Overview:
- Owns the configId/configData broadcast bus feeding one vectorVectorALU instance, addressed by its PERSONAL_CONFIG_ID.
- The host fills a shadow firmware table of MAX_CHAINS*6 bytes at any time outside a load.
- On request, and only while tracing is low, the block streams the whole table to the ALU in field-major order.
- The stream is framed by idle IDs so that the ALU's internal byte counter starts at 0 and resets afterwards.

Parameters:
- MAX_CHAINS, 4, number of chains; must match the ALU.
- TARGET_CONFIG_ID, 0, configId value that selects the target ALU.
- IDLE_CONFIG_ID, 8'hFF, configId driven when not streaming; must differ from every real ID.
- TOTAL_BYTES, MAX_CHAINS*6, derived; not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tracing  in  1  global trace enable; the ALU accepts config only when this is 0
- host_wr_en  in  1  shadow-table write strobe
- host_wr_addr  in  $clog2(TOTAL_BYTES)  byte index, computed as field*MAX_CHAINS + chain
- host_wr_data  in  8  byte to store
- start  in  1  load request, single-cycle pulse
- configId  out  8  config bus ID, registered
- configData  out  8  config bus data, registered
- busy  out  1  high from launch through the last streamed byte
- pending  out  1  start latched, waiting for tracing==0
- done  out  1  one-cycle pulse on successful completion
- aborted  out  1  one-cycle pulse when tracing rises mid-load
- wr_ignored  out  1  one-cycle pulse when a host write is dropped

Behaviour:
- Reset values and reset effect:
  - configId=IDLE_CONFIG_ID; configData, busy, pending, done, aborted and wr_ignored all 0.
  - State goes to IDLE and all shadow bytes are cleared to 0.
  - Reset asserted mid-stream: configId=IDLE_CONFIG_ID on the next edge; no done or aborted pulse.
- Byte order: index j maps to field j/MAX_CHAINS and chain j%MAX_CHAINS. Fields are 0=op, 1=addr_rd, 2=cond, 3=cache, 4=cache_addr, 5=minicache.
- Shadow writes:
  - Accepted only when busy=0.
  - A write with busy=1, or with host_wr_addr>=TOTAL_BYTES, is dropped and pulses wr_ignored on the next cycle.
- start handling:
  - Sampled in IDLE only; start with busy=1 is ignored.
  - If tracing=0, launch on the next edge.
  - If tracing=1, set pending=1 and launch on the first cycle tracing is sampled 0.
  - A start while pending=1 has no extra effect.
- States: IDLE -> PRE -> STREAM -> POST -> IDLE.
  - PRE (1 cycle): configId=IDLE_CONFIG_ID, busy=1, pending cleared. Guarantees the ALU counter is 0.
  - STREAM (TOTAL_BYTES cycles): configId=TARGET_CONFIG_ID, configData=shadow[cnt]. cnt counts 0..TOTAL_BYTES-1, then moves to POST.
  - POST (1 cycle): configId=IDLE_CONFIG_ID, busy=0, done=1.
- Latency: start sampled at edge k with tracing=0 gives:
  - PRE outputs after edge k+1.
  - Byte 0 after edge k+2.
  - Last byte after edge k+1+TOTAL_BYTES.
  - done after edge k+2+TOTAL_BYTES.
- Abort:
  - tracing sampled 1 in PRE or STREAM -> next cycle configId=IDLE_CONFIG_ID, aborted=1, busy=0, state IDLE.
  - Shadow is retained and pending is not re-armed; the host must reissue start.
- Simultaneous events:
  - start and host_wr_en in the same IDLE cycle: the write lands first and is included in the stream.
  - tracing rising in the same cycle the last byte is driven: still an abort.
- configData is 0 whenever configId≠TARGET_CONFIG_ID.

Decomposition:
- Package vvalu_cfg_pkg holds:
  - a field index enum, NUM_FIELDS=6, IDLE_CONFIG_ID_DEFAULT;
  - the state typedef {IDLE, PRE, STREAM, POST};
  - a function byte_index(field, chain).
- Sub-module vvalu_cfg_shadow: TOTAL_BYTES x 8 flop array with one synchronous write port and a combinational read port, cleared on reset.
- The FSM, counter and bus registers stay in the top level.

Test Plan:
- Load: write shadow[j]=j+1 for j=0..23, pulse start with tracing=0. The bus shows one IDLE (FF) cycle, then 24 cycles of ID 0 with data 1..24, then FF with done=1 exactly 26 cycles after start. A downstream ALU model then shows firmware_op[0..3]=1..4.
- Deferred start: pulse start with tracing=1 held for 10 cycles. pending=1 and configId stays FF throughout. PRE follows the cycle after tracing is sampled 0, and the full stream completes.
- Abort: raise tracing at STREAM byte 7. The next cycle has configId=FF, aborted=1, busy=0. A reissued start streams all 24 bytes again from byte 0.
- Write protection: host_wr_en at addr 3 during STREAM gives wr_ignored=1 and shadow[3] unchanged. A write to addr 24 when idle also gives wr_ignored=1.
- Reset mid-stream: assert reset at byte 12. configId=FF, all outputs 0, a read-back shows all shadow bytes 0, and no done pulse appears.
- Same-cycle write and start: write addr 0 = 8'hAA together with start. Byte 0 on the bus is 8'hAA.
